// File: rtl/fwd_pkg.sv
// rtl/fwd_pkg.sv - bypass select codes and scoreboard state type for fwd_hazard_unit
package fwd_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_LONG  = 2'b11;

  typedef enum logic {SB_IDLE, SB_BUSY} sb_state_t;

endpackage

// File: rtl/fwd_src_sel.sv
// rtl/fwd_src_sel.sv - bypass select for one EX source operand
module fwd_src_sel
  import fwd_pkg::*;
#(
  parameter int REGW = 5
) (
  input  logic [REGW-1:0] src,
  input  logic [REGW-1:0] exmem_rd,
  input  logic            exmem_regwrite,
  input  logic            long_wb,
  input  logic [REGW-1:0] long_rd,
  input  logic [REGW-1:0] memwb_rd,
  input  logic            memwb_regwrite,
  output logic [1:0]      sel
);

  // Youngest producer wins: EX/MEM, then the long unit, then MEM/WB.
  always_comb begin
    sel = FWD_RF;
    if (exmem_regwrite && exmem_rd != '0 && exmem_rd == src)
      sel = FWD_EXMEM;
    else if (long_wb && long_rd != '0 && long_rd == src)
      sel = FWD_LONG;
    else if (memwb_regwrite && memwb_rd != '0 && memwb_rd == src)
      sel = FWD_MEMWB;
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - operand bypass, load-use and long-op scoreboard stalls
// Optional statistics counters built when FWD_STATS_EN is defined.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int NSRC = 2,
  parameter int REGW = 5,
  parameter int LATW = 4,
  parameter int CNTW = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NSRC*REGW-1:0] id_src,
  input  logic [NSRC-1:0]      id_src_used,
  input  logic [REGW-1:0]      id_rd,
  input  logic                 id_regwrite,
  input  logic                 id_long,
  input  logic [NSRC*REGW-1:0] idex_src,
  input  logic [REGW-1:0]      idex_rd,
  input  logic                 idex_memread,
  input  logic                 long_issue,
  input  logic [LATW-1:0]      long_lat,
  input  logic [REGW-1:0]      exmem_rd,
  input  logic                 exmem_regwrite,
  input  logic [REGW-1:0]      memwb_rd,
  input  logic                 memwb_regwrite,
  output logic [NSRC*2-1:0]    fwd_sel,
  output logic                 stall,
  output logic                 flush_idex,
  output logic                 long_wb,
  output logic [REGW-1:0]      long_rd_o,
  output logic [CNTW-1:0]      stat_fwd,
  output logic [CNTW-1:0]      stat_stall
);

  sb_state_t       state;
  logic [LATW-1:0] cnt;
  logic [REGW-1:0] lrd;
  logic [LATW-1:0] lat_eff;

  assign lat_eff   = (long_lat == '0) ? LATW'(1) : long_lat;
  assign long_wb   = (state == SB_BUSY) && (cnt == LATW'(1));
  assign long_rd_o = lrd;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= SB_IDLE;
      cnt   <= '0;
      lrd   <= '0;
    end else begin
      case (state)
        SB_IDLE: begin
          if (long_issue) begin
            state <= SB_BUSY;
            cnt   <= lat_eff;
            lrd   <= idex_rd;
          end
        end
        SB_BUSY: begin
          if (cnt == LATW'(1)) begin
            // The writeback cycle can accept the next long op directly.
            if (long_issue) begin
              cnt <= lat_eff;
              lrd <= idex_rd;
            end else begin
              state <= SB_IDLE;
              cnt   <= '0;
            end
          end else begin
            cnt <= cnt - LATW'(1);
`ifndef SYNTHESIS
            if (long_issue)
              $error("fwd_hazard_unit: long_issue while long unit busy (cnt=%0d)", cnt);
`endif
          end
        end
        default: state <= SB_IDLE;
      endcase
    end
  end

  genvar g;
  generate
    for (g = 0; g < NSRC; g++) begin : g_src
      fwd_src_sel #(.REGW(REGW)) u_sel (
        .src            (idex_src[g*REGW +: REGW]),
        .exmem_rd       (exmem_rd),
        .exmem_regwrite (exmem_regwrite),
        .long_wb        (long_wb),
        .long_rd        (lrd),
        .memwb_rd       (memwb_rd),
        .memwb_regwrite (memwb_regwrite),
        .sel            (fwd_sel[g*2 +: 2])
      );
    end
  endgenerate

  logic busy_gt1;
  logic busy_gt2;
  assign busy_gt1 = (state == SB_BUSY) && (cnt > LATW'(1)) && (lrd != '0);
  assign busy_gt2 = (state == SB_BUSY) && (cnt > LATW'(2));

  always_comb begin
    stall = (busy_gt1 && id_regwrite && id_rd == lrd) || (busy_gt2 && id_long);
    for (int i = 0; i < NSRC; i++) begin
      if (id_src_used[i]) begin
        if (idex_memread && idex_rd != '0 && id_src[i*REGW +: REGW] == idex_rd)
          stall = 1'b1;
        if (busy_gt1 && id_src[i*REGW +: REGW] == lrd)
          stall = 1'b1;
      end
    end
  end

  assign flush_idex = stall;

`ifdef FWD_STATS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_fwd   <= '0;
      stat_stall <= '0;
    end else begin
      if ((|fwd_sel) && stat_fwd != '1)
        stat_fwd <= stat_fwd + CNTW'(1);
      if (stall && stat_stall != '1)
        stat_stall <= stat_stall + CNTW'(1);
    end
  end
`else
  assign stat_fwd   = '0;
  assign stat_stall = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - directed self-checking bench for fwd_hazard_unit
module tb_fwd_hazard_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [9:0]  id_src;
  logic [1:0]  id_src_used;
  logic [4:0]  id_rd;
  logic        id_regwrite;
  logic        id_long;
  logic [9:0]  idex_src;
  logic [4:0]  idex_rd;
  logic        idex_memread;
  logic        long_issue;
  logic [3:0]  long_lat;
  logic [4:0]  exmem_rd;
  logic        exmem_regwrite;
  logic [4:0]  memwb_rd;
  logic        memwb_regwrite;
  logic [3:0]  fwd_sel;
  logic        stall;
  logic        flush_idex;
  logic        long_wb;
  logic [4:0]  long_rd_o;
  logic [15:0] stat_fwd;
  logic [15:0] stat_stall;

  always #5 clock = ~clock;

  fwd_hazard_unit dut (
    .clock(clock), .reset_n(reset_n),
    .id_src(id_src), .id_src_used(id_src_used), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_long(id_long),
    .idex_src(idex_src), .idex_rd(idex_rd), .idex_memread(idex_memread),
    .long_issue(long_issue), .long_lat(long_lat),
    .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite),
    .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite),
    .fwd_sel(fwd_sel), .stall(stall), .flush_idex(flush_idex),
    .long_wb(long_wb), .long_rd_o(long_rd_o),
    .stat_fwd(stat_fwd), .stat_stall(stat_stall)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Model: the pending long op is described by the absolute cycle of its writeback.
  bit       pend;
  int       now;
  int       wb_time;
  logic [4:0] m_lrd;
  int       st_fwd;
  int       st_stall;
  bit       exp_any_fwd;
  bit       exp_stall_v;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, now);
    end
  endtask

  function automatic logic [1:0] m_sel(input logic [4:0] s, input bit lwb);
    if (exmem_regwrite && exmem_rd != 0 && exmem_rd == s) return 2'b10;
    if (lwb && m_lrd != 0 && m_lrd == s) return 2'b11;
    if (memwb_regwrite && memwb_rd != 0 && memwb_rd == s) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    pend = 0; st_fwd = 0; st_stall = 0;
  endtask

  task automatic compare_all();
    bit lwb;
    int rem;
    bit st;
    bit anyf;
    logic [1:0] sel;
    logic [4:0] s;
    lwb  = pend && (now == wb_time);
    rem  = wb_time - now + 1;
    st   = 0;
    anyf = 0;
    for (int i = 0; i < 2; i++) begin
      s = id_src[i*5 +: 5];
      if (idex_memread && idex_rd != 0 && id_src_used[i] && s == idex_rd) st = 1;
      if (pend && rem > 1 && m_lrd != 0 && id_src_used[i] && s == m_lrd) st = 1;
      sel = m_sel(idex_src[i*5 +: 5], lwb);
      if (sel != 2'b00) anyf = 1;
      chk($sformatf("fwd_sel%0d", i), 32'(fwd_sel[i*2 +: 2]), 32'(sel));
    end
    if (pend && rem > 1 && m_lrd != 0 && id_regwrite && id_rd == m_lrd) st = 1;
    if (pend && rem > 2 && id_long) st = 1;
    exp_any_fwd = anyf;
    exp_stall_v = st;
    chk("stall", 32'(stall), 32'(st));
    chk("flush_idex", 32'(flush_idex), 32'(st));
    chk("long_wb", 32'(long_wb), 32'(lwb));
    if (pend) chk("long_rd_o", 32'(long_rd_o), 32'(m_lrd));
`ifdef FWD_STATS_EN
    chk("stat_fwd", 32'(stat_fwd), 32'(st_fwd));
    chk("stat_stall", 32'(stat_stall), 32'(st_stall));
`else
    chk("stat_fwd", 32'(stat_fwd), 32'd0);
    chk("stat_stall", 32'(stat_stall), 32'd0);
`endif
  endtask

  task automatic model_update();
    if (!reset_n) begin
      model_reset();
    end else begin
      if (exp_any_fwd && st_fwd < 65535) st_fwd++;
      if (exp_stall_v && st_stall < 65535) st_stall++;
      if (pend && now == wb_time) pend = 0;
      if (long_issue && !pend) begin
        pend    = 1;
        wb_time = now + ((long_lat == 0) ? 1 : int'(long_lat));
        m_lrd   = idex_rd;
      end
    end
    now++;
  endtask

  task automatic clr();
    id_src = '0; id_src_used = '0; id_rd = '0; id_regwrite = 0; id_long = 0;
    idex_src = '0; idex_rd = '0; idex_memread = 0; long_issue = 0; long_lat = '0;
    exmem_rd = '0; exmem_regwrite = 0; memwb_rd = '0; memwb_regwrite = 0;
  endtask

  task automatic settle();
    @(negedge clock);
    compare_all();
  endtask

  task automatic adv();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic cyc();
    settle();
    adv();
  endtask

  typedef struct {
    logic [9:0] src;
    logic [4:0] erd; logic ewr;
    logic [4:0] mrd; logic mwr;
  } fvec_t;
  fvec_t fv[5];

  initial begin
    now = 0; wb_time = 0; m_lrd = '0; exp_any_fwd = 0; exp_stall_v = 0;
    model_reset();
    reset_n = 0;
    clr();
    settle();
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_long_wb", 32'(long_wb), 32'd0);
    adv();
    cyc();
    reset_n = 1;

    // EX/MEM over MEM/WB, then MEM/WB alone
    exmem_rd = 8; exmem_regwrite = 1; memwb_rd = 8; memwb_regwrite = 1;
    idex_src = {5'd3, 5'd8};
    settle();
    chk("t1_exmem_wins", 32'(fwd_sel[1:0]), 32'h2);
    chk("t1_src1_rf", 32'(fwd_sel[3:2]), 32'h0);
    adv();
    exmem_regwrite = 0;
    settle();
    chk("t1_memwb", 32'(fwd_sel[1:0]), 32'h1);
    adv();

    fv[0] = '{{5'd4, 5'd4}, 5'd4, 1'b1, 5'd0, 1'b0};
    fv[1] = '{{5'd0, 5'd0}, 5'd0, 1'b1, 5'd0, 1'b1};
    fv[2] = '{{5'd7, 5'd6}, 5'd6, 1'b1, 5'd7, 1'b1};
    fv[3] = '{{5'd31, 5'd30}, 5'd31, 1'b0, 5'd31, 1'b1};
    fv[4] = '{{5'd2, 5'd1}, 5'd3, 1'b1, 5'd4, 1'b1};
    foreach (fv[k]) begin
      idex_src = fv[k].src; exmem_rd = fv[k].erd; exmem_regwrite = fv[k].ewr;
      memwb_rd = fv[k].mrd; memwb_regwrite = fv[k].mwr;
      cyc();
    end
    clr();

    // load-use
    idex_memread = 1; idex_rd = 9; id_src = {5'd9, 5'd4}; id_src_used = 2'b10;
    settle();
    chk("t2_stall", 32'(stall), 32'd1);
    chk("t2_flush", 32'(flush_idex), 32'd1);
    adv();
    id_src_used = 2'b01;
    settle();
    chk("t2_unused", 32'(stall), 32'd0);
    adv();
    clr();

    // long op latency 4 to r10
    long_issue = 1; long_lat = 4; idex_rd = 10;
    cyc();
    clr();
    id_src[4:0] = 10; id_src_used = 2'b01;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk($sformatf("t3_raw_stall%0d", k), 32'(stall), 32'd1);
      adv();
    end
    idex_src[4:0] = 10;
    settle();
    chk("t3_long_wb", 32'(long_wb), 32'd1);
    chk("t3_long_rd", 32'(long_rd_o), 32'd10);
    chk("t3_fwd_long", 32'(fwd_sel[1:0]), 32'h3);
    chk("t3_no_stall", 32'(stall), 32'd0);
    adv();
    clr();
    settle();
    chk("t3_wb_done", 32'(long_wb), 32'd0);
    adv();

    // rd 0 never stalls; latency 0 writes back next cycle
    long_issue = 1; long_lat = 3; idex_rd = 0;
    cyc();
    clr();
    id_src_used = 2'b11;
    settle();
    chk("t4_rd0_nostall", 32'(stall), 32'd0);
    adv();
    cyc();
    cyc();
    clr();
    long_issue = 1; long_lat = 0; idex_rd = 5;
    cyc();
    clr();
    settle();
    chk("t4_lat0_wb", 32'(long_wb), 32'd1);
    chk("t4_lat0_rd", 32'(long_rd_o), 32'd5);
    adv();
    settle();
    chk("t4_lat0_done", 32'(long_wb), 32'd0);
    adv();

    // back-to-back long ops
    long_issue = 1; long_lat = 2; idex_rd = 11;
    cyc();
    clr();
    id_long = 1;
    settle();
    chk("t5_long_cnt2", 32'(stall), 32'd0);
    adv();
    clr();
    long_issue = 1; long_lat = 3; idex_rd = 12;
    settle();
    chk("t5_reload_wb", 32'(long_wb), 32'd1);
    chk("t5_reload_rd", 32'(long_rd_o), 32'd11);
    adv();
    clr();
    id_src[4:0] = 12; id_src_used = 2'b01;
    settle();
    chk("t5_busy_raw", 32'(stall), 32'd1);
    adv();
    clr();
    id_regwrite = 1; id_rd = 12;
    settle();
    chk("t5_waw", 32'(stall), 32'd1);
    adv();
    clr();
    id_long = 1;
    settle();
    chk("t5_wb2", 32'(long_wb), 32'd1);
    chk("t5_wb2_rd", 32'(long_rd_o), 32'd12);
    adv();
    clr();
    cyc();

    // async reset while busy
    long_issue = 1; long_lat = 5; idex_rd = 13;
    cyc();
    clr();
    id_src[4:0] = 13; id_src_used = 2'b01;
    cyc();
    cyc();
    settle();
    chk("t6_pre_stall", 32'(stall), 32'd1);
    reset_n = 0;
    model_reset();
    #1;
    chk("t6_rst_stall", 32'(stall), 32'd0);
    chk("t6_rst_flush", 32'(flush_idex), 32'd0);
    chk("t6_rst_wb", 32'(long_wb), 32'd0);
    adv();
    cyc();
    reset_n = 1;
    for (int k = 0; k < 6; k++) begin
      settle();
      chk($sformatf("t6_no_wb%0d", k), 32'(long_wb), 32'd0);
      adv();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
